// File: rtl/lcd_spi_sink.sv
// Receive end of the 4-wire LCD SPI link: decodes CASET/RASET/RAMWR into pixel writes.
// Build with LCD_SINK_CRC_EN defined to compute a CRC-16-CCITT per completed frame.
`timescale 1ns/1ps

module lcd_spi_sink #(
    parameter int LCD_W       = 132,
    parameter int LCD_H       = 162,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_rst_n_in,
    input  logic        lcd_cs_n_in,
    input  logic        lcd_dc_in,
    input  logic        lcd_clk_in,
    input  logic        lcd_data_in,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done,
    output logic        param_err,
    output logic [15:0] frame_crc
);

    localparam logic [7:0] X_MAX     = 8'(LCD_W - 1);
    localparam logic [7:0] Y_MAX     = 8'(LCD_H - 1);
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR,
        ST_SKIP
    } state_t;

    // Input synchronizers; CS_N idles high so it resets to the deselected level.
    logic [SYNC_STAGES-1:0] rst_n_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_n_sync <= '0;
            cs_n_sync  <= '1;
            dc_sync    <= '0;
            sck_sync   <= '0;
            mosi_sync  <= '0;
        end else begin
            rst_n_sync <= {rst_n_sync[SYNC_STAGES-2:0], lcd_rst_n_in};
            cs_n_sync  <= {cs_n_sync[SYNC_STAGES-2:0], lcd_cs_n_in};
            dc_sync    <= {dc_sync[SYNC_STAGES-2:0], lcd_dc_in};
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], lcd_clk_in};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], lcd_data_in};
        end
    end

    logic srst;
    logic cs_n_s;
    logic dc_s;
    logic sck_s;
    logic mosi_s;

    assign srst   = ~rst_n_sync[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Bit assembly: the 8th rising SCK edge completes a byte and latches DC with it.
    logic       sck_prev;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       byte_done;
    logic       byte_dc;
    logic [7:0] byte_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_prev  <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            byte_dc   <= 1'b0;
            byte_val  <= '0;
        end else if (srst) begin
            sck_prev  <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            byte_dc   <= 1'b0;
            byte_val  <= '0;
        end else begin
            sck_prev  <= sck_s;
            byte_done <= 1'b0;
            if (cs_n_s) begin
                bit_cnt <= '0;
            end else if (sck_s && !sck_prev) begin
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_val  <= {shift, mosi_s};
                    byte_dc   <= dc_s;
                end else begin
                    shift <= {shift[5:0], mosi_s};
                end
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    state_t     state_q;
    state_t     state_d;
    logic       cmd_fire;
    logic       param_fire;
    logic       hi_fire;
    logic       pix_fire;
    logic [1:0] param_cnt;
    logic       param_hi_nz;
    logic [7:0] s_coord;
    logic       hi_pend;
    logic [7:0] hi_byte;
    logic [7:0] win_xs;
    logic [7:0] win_xe;
    logic [7:0] win_ys;
    logic [7:0] win_ye;
    logic [7:0] cur_x;
    logic [7:0] cur_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A command byte always wins: it aborts whatever the decoder was doing.
    always_comb begin
        state_d    = state_q;
        cmd_fire   = 1'b0;
        param_fire = 1'b0;
        hi_fire    = 1'b0;
        pix_fire   = 1'b0;
        if (byte_done) begin
            if (!byte_dc) begin
                cmd_fire = 1'b1;
                case (byte_val)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_RASET: state_d = ST_RASET;
                    CMD_RAMWR: state_d = ST_RAMWR;
                    default:   state_d = ST_SKIP;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        param_fire = 1'b1;
                        if (param_cnt == 2'd3) begin
                            state_d = ST_SKIP;
                        end
                    end
                    ST_RAMWR: begin
                        hi_fire  = !hi_pend;
                        pix_fire = hi_pend;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Coordinates above 255 saturate to 0xFF; the end coordinate is clamped to the panel.
    logic [7:0] coord;
    logic [7:0] coord_lim;
    logic [7:0] e_clamp;
    logic       win_bad;
    logic       x_last;
    logic       y_last;

    always_comb begin
        coord     = param_hi_nz ? 8'hFF : byte_val;
        coord_lim = (state_q == ST_CASET) ? X_MAX : Y_MAX;
        e_clamp   = (coord > coord_lim) ? coord_lim : coord;
        win_bad   = s_coord > e_clamp;
        x_last    = cur_x == win_xe;
        y_last    = cur_y == win_ye;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            param_cnt   <= '0;
            param_hi_nz <= 1'b0;
            s_coord     <= '0;
            hi_pend     <= 1'b0;
            hi_byte     <= '0;
            win_xs      <= '0;
            win_xe      <= X_MAX;
            win_ys      <= '0;
            win_ye      <= Y_MAX;
            cur_x       <= '0;
            cur_y       <= '0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_done  <= 1'b0;
            param_err   <= 1'b0;
        end else if (srst) begin
            param_cnt   <= '0;
            param_hi_nz <= 1'b0;
            s_coord     <= '0;
            hi_pend     <= 1'b0;
            hi_byte     <= '0;
            win_xs      <= '0;
            win_xe      <= X_MAX;
            win_ys      <= '0;
            win_ye      <= Y_MAX;
            cur_x       <= '0;
            cur_y       <= '0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_done  <= 1'b0;
            param_err   <= 1'b0;
        end else begin
            cmd_valid  <= cmd_fire;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            param_err  <= 1'b0;

            if (cmd_fire) begin
                cmd_byte  <= byte_val;
                hi_pend   <= 1'b0;
                param_cnt <= '0;
                if (byte_val == CMD_RAMWR) begin
                    cur_x <= win_xs;
                    cur_y <= win_ys;
                end
            end

            if (param_fire) begin
                param_cnt <= param_cnt + 2'd1;
                case (param_cnt)
                    2'd0, 2'd2: param_hi_nz <= |byte_val;
                    2'd1:       s_coord     <= coord;
                    default: begin
                        if (win_bad) begin
                            param_err <= 1'b1;
                        end else if (state_q == ST_CASET) begin
                            win_xs <= s_coord;
                            win_xe <= e_clamp;
                        end else begin
                            win_ys <= s_coord;
                            win_ye <= e_clamp;
                        end
                    end
                endcase
            end

            if (hi_fire) begin
                hi_byte <= byte_val;
                hi_pend <= 1'b1;
            end

            // Raster walk inside the window; the last pixel wraps back to the window origin.
            if (pix_fire) begin
                pix_valid <= 1'b1;
                pix_x     <= cur_x;
                pix_y     <= cur_y;
                pix_data  <= {hi_byte, byte_val};
                hi_pend   <= 1'b0;
                if (x_last) begin
                    cur_x <= win_xs;
                    if (y_last) begin
                        cur_y      <= win_ys;
                        frame_done <= 1'b1;
                    end else begin
                        cur_y <= cur_y + 8'd1;
                    end
                end else begin
                    cur_x <= cur_x + 8'd1;
                end
            end
        end
    end

`ifdef LCD_SINK_CRC_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    logic [15:0] crc_q;
    logic [15:0] crc_pix;

    assign crc_pix = crc_byte(crc_byte(crc_q, hi_byte), byte_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q     <= 16'hFFFF;
            frame_crc <= '0;
        end else if (srst) begin
            crc_q     <= 16'hFFFF;
            frame_crc <= '0;
        end else if (cmd_fire && byte_val == CMD_RAMWR) begin
            crc_q <= 16'hFFFF;
        end else if (pix_fire) begin
            if (x_last && y_last) begin
                crc_q     <= 16'hFFFF;
                frame_crc <= crc_pix;
            end else begin
                crc_q <= crc_pix;
            end
        end
    end
`else
    assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Bench for lcd_spi_sink: serial SPI driver, queue-based reference model, per-cycle monitor.
`timescale 1ns/1ps

module tb_lcd_spi_sink;
  localparam int LCD_W       = 132;
  localparam int LCD_H       = 162;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 30;

  logic        clk;
  logic        rst;
  logic        lcd_rst_n_in;
  logic        lcd_cs_n_in;
  logic        lcd_dc_in;
  logic        lcd_clk_in;
  logic        lcd_data_in;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_done;
  logic        param_err;
  logic [15:0] frame_crc;

  lcd_spi_sink #(.LCD_W(LCD_W), .LCD_H(LCD_H), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .lcd_rst_n_in(lcd_rst_n_in), .lcd_cs_n_in(lcd_cs_n_in),
    .lcd_dc_in(lcd_dc_in), .lcd_clk_in(lcd_clk_in), .lcd_data_in(lcd_data_in),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_data(pix_data), .frame_done(frame_done), .param_err(param_err),
    .frame_crc(frame_crc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // scoreboard: expected pixels {frame_done, x, y, data}, commands, error strobes
  logic [32:0] exp_q[$];
  logic [7:0]  cmd_q[$];
  int          err_exp;
  logic [32:0] log_pix[$];
  int          cmd_seen;
  int          err_seen;
`ifdef LCD_SINK_CRC_EN
  logic [15:0] crc_exp_q[$];
  logic [15:0] m_crc;
`endif

  // reference model state
  int          m_mode;  // 0 idle, 1 caset, 2 raset, 3 ramwr, 4 skip
  int          m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
  bit          m_hi_pend;
  logic [7:0]  m_hi;
  int          m_par[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data,
                frame_done, param_err, frame_crc});
  endfunction

  function automatic int coord_of(input int hi, input int lo);
    return (hi != 0) ? 255 : lo;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_xs = 0; m_xe = LCD_W - 1; m_ys = 0; m_ye = LCD_H - 1;
    m_cx = 0; m_cy = 0;
    m_hi_pend = 1'b0;
    m_hi = 8'h00;
    m_par.delete();
    exp_q.delete();
    cmd_q.delete();
    err_exp = 0;
`ifdef LCD_SINK_CRC_EN
    crc_exp_q.delete();
    m_crc = 16'hFFFF;
`endif
  endtask

`ifdef LCD_SINK_CRC_EN
  // CRC-16-CCITT as a bit stream, MSB of each byte first.
  task automatic model_crc16(input logic [15:0] word);
    logic fb;
    for (int i = 15; i >= 0; i--) begin
      fb = m_crc[15] ^ word[i];
      m_crc = {m_crc[14:0], 1'b0};
      if (fb) m_crc = m_crc ^ 16'h1021;
    end
  endtask
`endif

  task automatic model_byte(input bit dc, input logic [7:0] b);
    int s, e, lim;
    bit fd;
    if (!dc) begin
      cmd_q.push_back(b);
      m_hi_pend = 1'b0;
      m_par.delete();
      case (b)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin
          m_mode = 3;
          m_cx = m_xs;
          m_cy = m_ys;
`ifdef LCD_SINK_CRC_EN
          m_crc = 16'hFFFF;
`endif
        end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(int'(b));
      if (m_par.size() == 4) begin
        s = coord_of(m_par[0], m_par[1]);
        e = coord_of(m_par[2], m_par[3]);
        lim = (m_mode == 1) ? LCD_W - 1 : LCD_H - 1;
        if (e > lim) e = lim;
        if (s > e) err_exp++;
        else if (m_mode == 1) begin m_xs = s; m_xe = e; end
        else begin m_ys = s; m_ye = e; end
        m_mode = 4;
      end
    end else if (m_mode == 3) begin
      if (!m_hi_pend) begin
        m_hi = b;
        m_hi_pend = 1'b1;
      end else begin
        m_hi_pend = 1'b0;
        fd = (m_cx == m_xe) && (m_cy == m_ye);
        exp_q.push_back({fd, 8'(m_cx), 8'(m_cy), m_hi, b});
`ifdef LCD_SINK_CRC_EN
        model_crc16({m_hi, b});
        if (fd) begin
          crc_exp_q.push_back(m_crc);
          m_crc = 16'hFFFF;
        end
`endif
        if (m_cx == m_xe) begin
          m_cx = m_xs;
          m_cy = (m_cy == m_ye) ? m_ys : m_cy + 1;
        end else begin
          m_cx = m_cx + 1;
        end
      end
    end
  endtask

  // driver tasks
  task automatic spi_bit(input logic b);
    lcd_data_in = b;
    #HALF lcd_clk_in = 1'b1;
    #HALF lcd_clk_in = 1'b0;
  endtask

  task automatic spi_byte(input bit dc, input logic [7:0] b);
    if (lcd_cs_n_in) begin
      lcd_cs_n_in = 1'b0;
      #HALF;
    end
    lcd_dc_in = dc;
    model_byte(dc, b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic spi_partial(input int nbits);
    if (lcd_cs_n_in) begin
      lcd_cs_n_in = 1'b0;
      #HALF;
    end
    lcd_dc_in = 1'($urandom_range(0, 1));
    for (int i = 0; i < nbits; i++) spi_bit(1'($urandom_range(0, 1)));
    #HALF lcd_cs_n_in = 1'b1;
    #(3 * HALF);
  endtask

  task automatic cs_gap();
    lcd_cs_n_in = 1'b1;
    #(4 * HALF);
  endtask

  task automatic pixel(input logic [15:0] d);
    spi_byte(1'b1, d[15:8]);
    spi_byte(1'b1, d[7:0]);
  endtask

  task automatic sync_tb();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_q.size() != 0 || err_exp != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0 || cmd_q.size() != 0 || err_exp != 0)
      fail_now("drain", $sformatf("outstanding pix=%0d cmd=%0d err=%0d, required 0",
               exp_q.size(), cmd_q.size(), err_exp));
  endtask

  task automatic set_win(input logic [7:0] cmd, input logic [7:0] sh, input logic [7:0] sl,
                         input logic [7:0] eh, input logic [7:0] el);
    spi_byte(1'b0, cmd);
    spi_byte(1'b1, sh);
    spi_byte(1'b1, sl);
    spi_byte(1'b1, eh);
    spi_byte(1'b1, el);
  endtask

  // compare process: checks every strobe against the model queues
  task automatic monitor();
    logic [32:0] obs;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (pix_valid) begin
        obs = {frame_done, pix_x, pix_y, pix_data};
        log_pix.push_back(obs);
        if (exp_q.size() == 0) begin
          fail_now("pix_unexpected", $sformatf("got x=%0d y=%0d data=0x%0h, required none",
                   pix_x, pix_y, pix_data));
        end else begin
          e = exp_q.pop_front();
          check("pix", 64'(obs), 64'(e));
`ifdef LCD_SINK_CRC_EN
          if (e[32] && crc_exp_q.size() != 0) check("frame_crc", 64'(frame_crc), 64'(crc_exp_q.pop_front()));
`else
          check("frame_crc_off", 64'(frame_crc), 64'd0);
`endif
        end
      end else if (frame_done) begin
        fail_now("frame_done_alone", "got 1 without pix_valid, required 0");
      end
      if (cmd_valid) begin
        cmd_seen++;
        if (cmd_q.size() == 0) fail_now("cmd_unexpected", $sformatf("got 0x%0h, required none", cmd_byte));
        else check("cmd_byte", 64'(cmd_byte), 64'(cmd_q.pop_front()));
      end
      if (param_err) begin
        err_seen++;
        if (err_exp == 0) fail_now("param_err_unexpected", "got 1, required 0");
        else begin
          err_exp--;
          tests++;
        end
      end
    end
  endtask

  task automatic rand_window(input bit is_x);
    int lim, s, e, tmp;
    logic [7:0] sh, eh;
    lim = is_x ? LCD_W : LCD_H;
    s = $urandom_range(0, lim + 3);
    e = s + $urandom_range(0, 3);
    if ($urandom_range(0, 4) == 0) begin
      tmp = s; s = e + 1; e = tmp;
    end
    sh = ($urandom_range(0, 11) == 0) ? 8'h01 : 8'h00;
    eh = ($urandom_range(0, 11) == 0) ? 8'h02 : 8'h00;
    set_win(is_x ? 8'h2A : 8'h2B, sh, 8'(s), eh, 8'(e));
    if ($urandom_range(0, 3) == 0) spi_byte(1'b1, 8'($urandom_range(0, 255)));
  endtask

  initial begin
    int c0, e0, n;
    int lx[7];
    int ly[7];
    lx = '{16, 17, 18, 16, 17, 18, 16};
    ly = '{32, 32, 32, 33, 33, 33, 32};
    tests = 0; fails = 0; cmd_seen = 0; err_seen = 0;
    rst = 1'b1; lcd_rst_n_in = 1'b1; lcd_cs_n_in = 1'b1; lcd_dc_in = 1'b0;
    lcd_clk_in = 1'b0; lcd_data_in = 1'b0;
    model_reset();
    fork
      monitor();
      begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the end within 3 ms");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", all_outs(), 64'd0);
    #1 rst = 1'b0;
    repeat (SYNC_STAGES + 3) @(posedge clk);
    #2 check("post_reset_outputs", all_outs(), 64'd0);

    // async reset in the middle of RAMWR, then a clean first pixel
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'hF8);
    drain();
    #3 rst = 1'b1;
    #1 check("rst_async_outputs", all_outs(), 64'd0);
    model_reset();
    log_pix.delete();
    sync_tb();
    rst = 1'b0;
    repeat (SYNC_STAGES + 3) @(posedge clk);
    #2;
    spi_byte(1'b0, 8'h2C);
    pixel(16'hF800);
    drain();
    check("rst_pix_count", 64'(log_pix.size()), 64'd1);
    if (log_pix.size() >= 1) check("rst_first_pix", 64'(log_pix[0]), 64'({1'b0, 8'd0, 8'd0, 16'hF800}));

    // window walk with wrap
    log_pix.delete();
    set_win(8'h2A, 8'h00, 8'h10, 8'h00, 8'h12);
    set_win(8'h2B, 8'h00, 8'h20, 8'h00, 8'h21);
    spi_byte(1'b0, 8'h2C);
    for (int i = 0; i < 7; i++) pixel(16'($urandom_range(0, 65535)));
    drain();
    check("win_pix_count", 64'(log_pix.size()), 64'd7);
    for (int i = 0; i < 7 && i < log_pix.size(); i++) begin
      check($sformatf("win_xy_%0d", i), 64'(log_pix[i][31:16]), 64'({8'(lx[i]), 8'(ly[i])}));
      check($sformatf("win_fd_%0d", i), 64'(log_pix[i][32]), 64'(i == 5));
    end

    // partial byte discarded on CS_N high
    c0 = cmd_seen;
    spi_partial(5);
    spi_byte(1'b0, 8'h2C);
    drain();
    check("partial_cmd_count", 64'(cmd_seen - c0), 64'd1);
    check("partial_cmd_byte", 64'(cmd_byte), 64'h2C);

    // rejected window keeps the previous xs; clamp of xe
    log_pix.delete();
    e0 = err_seen;
    set_win(8'h2A, 8'h00, 8'h05, 8'h00, 8'h09);
    set_win(8'h2A, 8'h00, 8'h20, 8'h00, 8'h10);
    spi_byte(1'b0, 8'h2C);
    pixel(16'h0F0F);
    drain();
    check("err_count", 64'(err_seen - e0), 64'd1);
    if (log_pix.size() >= 1) check("err_keeps_xs", 64'(log_pix[0][31:24]), 64'd5);
    log_pix.delete();
    set_win(8'h2A, 8'h00, 8'h80, 8'h00, 8'hFF);
    set_win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h05);
    spi_byte(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) pixel(16'($urandom_range(0, 65535)));
    drain();
    check("clamp_pix_count", 64'(log_pix.size()), 64'd5);
    if (log_pix.size() >= 5) begin
      check("clamp_last_col", 64'(log_pix[3][31:16]), 64'({8'd131, 8'd0}));
      check("clamp_wrap", 64'(log_pix[4][31:16]), 64'({8'd128, 8'd1}));
    end

    // abort of a pending high byte by a command
    log_pix.delete();
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'hAB);
    spi_byte(1'b0, 8'h00);
    spi_byte(1'b0, 8'h2C);
    pixel(16'h1234);
    drain();
    check("abort_pix_count", 64'(log_pix.size()), 64'd1);
    if (log_pix.size() >= 1) check("abort_pix_data", 64'(log_pix[0][15:0]), 64'h1234);

    // panel reset from the link
    lcd_rst_n_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1 check("lcd_rst_outputs", all_outs(), 64'd0);
    model_reset();
    sync_tb();
    lcd_rst_n_in = 1'b1;
    repeat (SYNC_STAGES + 3) @(posedge clk);
    #2;
    log_pix.delete();
    spi_byte(1'b0, 8'h2C);
    pixel(16'hBEEF);
    drain();
    if (log_pix.size() >= 1) check("lcd_rst_origin", 64'(log_pix[0][31:16]), 64'd0);
    else fail_now("lcd_rst_origin", "got no pixel, required one at (0,0)");

`ifdef LCD_SINK_CRC_EN
    // 1x1 window, single black pixel
    set_win(8'h2A, 8'h00, 8'h07, 8'h00, 8'h07);
    set_win(8'h2B, 8'h00, 8'h03, 8'h00, 8'h03);
    spi_byte(1'b0, 8'h2C);
    pixel(16'h0000);
    drain();
`endif

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 9))
        0, 1: rand_window(1'b1);
        2, 3: rand_window(1'b0);
        4, 5, 6: begin
          spi_byte(1'b0, 8'h2C);
          n = $urandom_range(1, 10);
          for (int p = 0; p < n; p++) begin
            spi_byte(1'b1, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) cs_gap();
            spi_byte(1'b1, 8'($urandom_range(0, 255)));
          end
        end
        7: begin
          spi_byte(1'b0, 8'($urandom_range(0, 255)));
          n = $urandom_range(0, 2);
          for (int p = 0; p < n; p++) spi_byte(1'b1, 8'($urandom_range(0, 255)));
        end
        8: spi_partial($urandom_range(1, 7));
        default: spi_byte(1'b1, 8'($urandom_range(0, 255)));
      endcase
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
